tx_interface: RTL and testbench

- Return-path framer for the UART calculator: serialises one ALU result into NUM_BYTES bytes for the UART transmitter.
- Sits between the ALU output and the UART tx core, mirroring the rx-side operand/opcode collector.
- Latches the result on a rising edge of the result-valid strobe, then sends it LSB byte first.
- Each byte is launched with a one-cycle start pulse; the block waits for the transmitter's done edge before the next byte.

---
 rtl/tx_interface.sv | 106 ++++++++++
 tb/tb_tx_interface.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/tx_interface.sv
`default_nettype none
// ============================================================================
// Module   : tx_interface
// Purpose  : Return-path framer for the UART calculator. Latches one ALU
//            result on a rising edge of the result-valid strobe and hands it
//            to the UART tx core LSB byte first, one start pulse per byte,
//            waiting for the transmitter's done edge between bytes.
// Revision : 1.0  initial release
// ============================================================================
module tx_interface #(
  parameter int DATA_BITS = 8,
  parameter int NUM_BYTES = 2
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_result_valid,
  input  logic [DATA_BITS*NUM_BYTES-1:0] i_result,
  input  logic                           i_tx_done,
  output logic                           o_tx_start,
  output logic [DATA_BITS-1:0]           o_tx_data,
  output logic                           o_busy,
  output logic                           o_overrun,
  output logic [3:0]                     o_state
);

  localparam int CNT_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(NUM_BYTES - 1);

  localparam logic [3:0] ST_IDLE  = 4'b0001;
  localparam logic [3:0] ST_START = 4'b0010;
  localparam logic [3:0] ST_WAIT  = 4'b0100;
  localparam logic [3:0] ST_NEXT  = 4'b1000;

  logic [3:0]                     state;
  logic [DATA_BITS*NUM_BYTES-1:0] shift;
  logic [CNT_W-1:0]               byte_cnt;
  logic                           overrun;
  logic                           valid_d;
  logic                           done_d;
  logic                           rise_valid;
  logic                           rise_done;

  // Edge-detect history; deliberately not reset so a level held high
  // through reset is not mistaken for a fresh edge afterwards.
  always_ff @(posedge i_clk) begin
    valid_d <= i_result_valid;
    done_d  <= i_tx_done;
  end

  assign rise_valid = i_result_valid & ~valid_d;
  assign rise_done  = i_tx_done & ~done_d;

  // Framing FSM: latch result, pulse start per byte, advance on done edge.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= ST_IDLE;
      shift    <= '0;
      byte_cnt <= '0;
      overrun  <= 1'b0;
    end else begin
      // A valid edge outside IDLE is dropped; only the sticky flag records it.
      if (rise_valid && (state != ST_IDLE)) begin
        overrun <= 1'b1;
      end
      case (state)
        ST_IDLE: begin
          if (rise_valid) begin
            shift    <= i_result;
            byte_cnt <= '0;
            overrun  <= 1'b0;
            state    <= ST_START;
          end
        end
        ST_START: begin
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (rise_done) begin
            if (byte_cnt == LAST_BYTE) begin
              state <= ST_IDLE;
            end else begin
              state <= ST_NEXT;
            end
          end
        end
        ST_NEXT: begin
          shift    <= shift >> DATA_BITS;
          byte_cnt <= byte_cnt + CNT_W'(1);
          state    <= ST_START;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Outputs decode registered state only; no input-to-output paths.
  assign o_tx_start = (state == ST_START);
  assign o_tx_data  = shift[DATA_BITS-1:0];
  assign o_busy     = (state != ST_IDLE);
  assign o_overrun  = overrun;
  assign o_state    = state;

endmodule
`default_nettype wire

// File: tb/tb_tx_interface.sv
`default_nettype none
// ============================================================================
// Module   : tb_tx_interface
// Purpose  : Self-checking bench for tx_interface (DATA_BITS=8, NUM_BYTES=2).
//            Expected bytes go into a scoreboard queue when a result is
//            driven and are popped whenever the DUT pulses o_tx_start.
// Revision : 1.0  initial release
// ============================================================================
module tb_tx_interface;

  logic        i_clk;
  logic        i_rst;
  logic        i_result_valid;
  logic [15:0] i_result;
  logic        i_tx_done;
  logic        o_tx_start;
  logic [7:0]  o_tx_data;
  logic        o_busy;
  logic        o_overrun;
  logic [3:0]  o_state;

  tx_interface #(.DATA_BITS(8), .NUM_BYTES(2)) dut (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_result_valid (i_result_valid),
    .i_result       (i_result),
    .i_tx_done      (i_tx_done),
    .o_tx_start     (o_tx_start),
    .o_tx_data      (o_tx_data),
    .o_busy         (o_busy),
    .o_overrun      (o_overrun),
    .o_state        (o_state)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [15:0] result;
    logic [7:0]  b0;
    logic [7:0]  b1;
  } vec_t;

  vec_t       vecs [4];
  logic [7:0] sb [$];
  int         total = 0;
  int         bad   = 0;
  int         n_starts = 0;
  logic       prev_start = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock; outputs sampled at the falling edge. Every start pulse is
  // checked against the scoreboard and for single-cycle width.
  task automatic tick();
    logic [7:0] exp_b;
    @(negedge i_clk);
    if (o_tx_start) begin
      n_starts++;
      check("start_width_prev", {31'd0, prev_start}, 32'd0);
      if (sb.size() == 0) begin
        check("unexpected_start", 32'd1, 32'd0);
      end else begin
        exp_b = sb.pop_front();
        check("tx_data", {24'd0, o_tx_data}, {24'd0, exp_b});
      end
    end
    prev_start = o_tx_start;
  endtask

  task automatic do_done();
    i_tx_done = 1'b1;
    tick();
    i_tx_done = 1'b0;
  endtask

  // From the WAIT state of byte 0, finish both bytes and settle in IDLE.
  task automatic finish_xfer();
    repeat (5) tick();
    do_done();
    tick();
    repeat (5) tick();
    do_done();
    tick();
  endtask

  task automatic launch(input logic [15:0] r, input logic [7:0] b0, input logic [7:0] b1);
    i_result       = r;
    i_result_valid = 1'b1;
    sb.push_back(b0);
    sb.push_back(b1);
    tick();
    i_result_valid = 1'b0;
    tick();
  endtask

  initial begin
    int s0;
    vecs[0] = '{result: 16'hA55A, b0: 8'h5A, b1: 8'hA5};
    vecs[1] = '{result: 16'h1234, b0: 8'h34, b1: 8'h12};
    vecs[2] = '{result: 16'h00C3, b0: 8'hC3, b1: 8'h00};
    vecs[3] = '{result: 16'hFFFF, b0: 8'hFF, b1: 8'hFF};

    i_rst = 1'b1; i_result_valid = 1'b0; i_result = 16'h0; i_tx_done = 1'b0;
    repeat (3) tick();
    check("rst_state",   {28'd0, o_state}, 32'h1);
    check("rst_data",    {24'd0, o_tx_data}, 32'h0);
    check("rst_busy",    {31'd0, o_busy}, 32'h0);
    check("rst_overrun", {31'd0, o_overrun}, 32'h0);
    check("rst_start",   {31'd0, o_tx_start}, 32'h0);
    i_rst = 1'b0;
    repeat (2) tick();

    // Table-driven transfers with detailed timing checks.
    for (int i = 0; i < 4; i++) begin
      i_result       = vecs[i].result;
      i_result_valid = 1'b1;
      sb.push_back(vecs[i].b0);
      sb.push_back(vecs[i].b1);
      tick();
      check("valid_to_start", {31'd0, o_tx_start}, 32'd1);
      check("busy_in_start",  {31'd0, o_busy}, 32'd1);
      i_result_valid = 1'b0;
      i_result       = 16'hDEAD;
      tick();
      check("start_one_cycle", {31'd0, o_tx_start}, 32'd0);
      check("wait_state",      {28'd0, o_state}, 32'h4);
      repeat (8) tick();
      check("data_stable_b0",  {24'd0, o_tx_data}, {24'd0, vecs[i].b0});
      do_done();
      check("next_state",      {28'd0, o_state}, 32'h8);
      tick();
      check("done_to_start",   {31'd0, o_tx_start}, 32'd1);
      repeat (9) tick();
      check("busy_before_last", {31'd0, o_busy}, 32'd1);
      do_done();
      check("idle_after_last", {28'd0, o_state}, 32'h1);
      check("busy_after_last", {31'd0, o_busy}, 32'd0);
      tick();
      check("sb_empty", sb.size(), 32'd0);
    end

    // Overrun: a second valid during byte 0 is dropped.
    launch(16'h1234, 8'h34, 8'h12);
    i_result = 16'hFFFF;
    i_result_valid = 1'b1;
    tick();
    i_result_valid = 1'b0;
    check("overrun_set",  {31'd0, o_overrun}, 32'd1);
    check("overrun_data", {24'd0, o_tx_data}, 32'h34);
    finish_xfer();
    check("overrun_sticky", {31'd0, o_overrun}, 32'd1);
    check("overrun_sb",     sb.size(), 32'd0);
    launch(16'h00C3, 8'hC3, 8'h00);
    check("overrun_clear",  {31'd0, o_overrun}, 32'd0);
    finish_xfer();

    // Level hold: valid high through reset, then a long done in IDLE.
    s0 = n_starts;
    i_result_valid = 1'b1;
    i_rst = 1'b1;
    repeat (3) tick();
    i_rst = 1'b0;
    repeat (5) tick();
    i_tx_done = 1'b1;
    repeat (20) tick();
    i_tx_done = 1'b0;
    i_result_valid = 1'b0;
    tick();
    check("level_no_start", n_starts - s0, 32'd0);
    check("level_idle",     {28'd0, o_state}, 32'h1);

    // Long done during WAIT advances exactly one byte.
    launch(16'hBEEF, 8'hEF, 8'hBE);
    s0 = n_starts;
    i_tx_done = 1'b1;
    repeat (20) tick();
    check("long_done_one",  n_starts - s0, 32'd1);
    check("long_done_wait", {28'd0, o_state}, 32'h4);
    i_tx_done = 1'b0;
    tick();
    do_done();
    check("long_done_idle", {28'd0, o_state}, 32'h1);
    tick();

    // Reset mid-transfer: second byte must never be launched.
    i_result = 16'hABCD;
    i_result_valid = 1'b1;
    sb.push_back(8'hCD);
    tick();
    i_result_valid = 1'b0;
    repeat (4) tick();
    s0 = n_starts;
    i_rst = 1'b1;
    tick();
    check("midrst_state", {28'd0, o_state}, 32'h1);
    check("midrst_data",  {24'd0, o_tx_data}, 32'h0);
    check("midrst_busy",  {31'd0, o_busy}, 32'd0);
    i_rst = 1'b0;
    repeat (20) tick();
    check("midrst_no_start", n_starts - s0, 32'd0);
    launch(16'h00C3, 8'hC3, 8'h00);
    finish_xfer();
    check("midrst_sb", sb.size(), 32'd0);

    // Final done coincides with a new valid edge: new result dropped.
    launch(16'h5555, 8'h55, 8'h55);
    repeat (5) tick();
    do_done();
    tick();
    repeat (5) tick();
    i_result = 16'h7777;
    i_result_valid = 1'b1;
    do_done();
    i_result_valid = 1'b0;
    check("simul_idle",    {28'd0, o_state}, 32'h1);
    check("simul_overrun", {31'd0, o_overrun}, 32'd1);
    s0 = n_starts;
    repeat (10) tick();
    check("simul_no_start", n_starts - s0, 32'd0);
    check("simul_sb",       sb.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
